// File: rtl/hub75_apb_regs.sv
// APB register block and frame-buffer write port for a HUB75 LED panel driver.
// Optional `HUB75_IRQ_EN adds the IRQ register (offset 4) and the swap-done interrupt.
module hub75_apb_regs #(
    parameter int  ADDR_W = 18,
    parameter int  PIX_W  = 16,
    localparam int FB_AW  = ADDR_W - 3
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [31:0]       pwdata_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    input  logic              frame_end_i,
    output logic [31:0]       control_o,
    output logic [9:0]        pixels_per_row_o,
    output logic              front_buf_o,
    output logic              irq_o,
    output logic              mem_wr_o,
    output logic [PIX_W-1:0]  mem_data_o,
    output logic [FB_AW:0]    mem_waddr_o
);

`ifdef HUB75_IRQ_EN
    localparam bit IRQ_MAP = 1'b1;
`else
    localparam bit IRQ_MAP = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_PENDING} swap_state_e;

    swap_state_e        state_q, state_d;
    logic               front_buf_q, front_buf_d;
    logic [31:0]        prdata_q, prdata_d;
    logic [31:0]        control_q, control_d;
    logic [9:0]         ppr_q, ppr_d;
    logic               mem_wr_q, mem_wr_d;
    logic [PIX_W-1:0]   mem_data_q, mem_data_d;
    logic [FB_AW:0]     mem_waddr_q, mem_waddr_d;

    logic               reg_sp, setup, access, reg_wr, px_wr, pending, swap_done;
    logic               is_stat, is_ctrl, is_ppr, is_swap, is_irq, mapped, bad_ppr;
    logic [FB_AW-1:0]   woff;
    logic [9:0]         ppr_new;
    logic [31:0]        rd_val;
    logic [PIX_W-1:0]   pix;
    logic               irq_pend, irq_en;
    logic               unused_addr;

    assign reg_sp  = paddr_i[ADDR_W-1];
    assign woff    = paddr_i[ADDR_W-2:2];
    assign setup   = psel_i & ~penable_i;
    assign access  = psel_i & penable_i;
    assign pending = (state_q == S_PENDING);
    assign unused_addr = ^paddr_i[1:0];

    assign is_stat = (woff == FB_AW'(0));
    assign is_ctrl = (woff == FB_AW'(1));
    assign is_ppr  = (woff == FB_AW'(2));
    assign is_swap = (woff == FB_AW'(3));
    assign is_irq  = (woff == FB_AW'(4));
    assign mapped  = is_stat | is_ctrl | is_ppr | is_swap | (IRQ_MAP & is_irq);

    // Row length is kept a multiple of 64; a write that rounds to zero is rejected.
    assign ppr_new = {pwdata_i[9:6], 6'b0};
    assign bad_ppr = is_ppr & pwrite_i & (ppr_new == 10'd0);

    assign reg_wr    = access & pwrite_i & reg_sp;
    assign pready_o  = ~(access & pwrite_i & ~reg_sp & pending);
    assign px_wr     = access & pwrite_i & ~reg_sp & pready_o;
    assign pslverr_o = access & reg_sp & (~mapped | bad_ppr);

    generate
        if (PIX_W == 16) begin : g_rgb565
            assign pix = {pwdata_i[23:19], pwdata_i[15:10], pwdata_i[7:3]};
        end else if (PIX_W == 24) begin : g_rgb888
            assign pix = pwdata_i[23:0];
        end else begin : g_bad_pix_w
            $error("hub75_apb_regs: PIX_W must be 16 or 24");
            assign pix = '0;
        end
    endgenerate

    always_comb begin
        rd_val = 32'h0;
        if (is_stat)      rd_val = {16'hB075, 13'b0, irq_pend, pending, front_buf_q};
        else if (is_ctrl) rd_val = control_q;
        else if (is_ppr)  rd_val = {22'b0, ppr_q};
        else if (is_irq)  rd_val = {30'b0, irq_en, irq_pend};
    end

    always_comb begin
        prdata_d    = prdata_q;
        control_d   = control_q;
        ppr_d       = ppr_q;
        mem_wr_d    = px_wr;
        mem_data_d  = mem_data_q;
        mem_waddr_d = mem_waddr_q;
        if (setup)
            prdata_d = (!pwrite_i && reg_sp && mapped) ? rd_val : 32'h0;
        if (reg_wr && is_ctrl)
            control_d = pwdata_i;
        if (reg_wr && is_ppr && !bad_ppr)
            ppr_d = ppr_new;
        // Pixels always land in the back buffer.
        if (px_wr) begin
            mem_data_d  = pix;
            mem_waddr_d = {~front_buf_q, woff};
        end
    end

    // Swap FSM: a pending swap completes on frame end, or at once if timing is disabled.
    always_comb begin
        state_d     = state_q;
        front_buf_d = front_buf_q;
        swap_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (reg_wr && is_swap && pwdata_i[0])
                    state_d = S_PENDING;
            end
            S_PENDING: begin
                if (frame_end_i || !control_q[0]) begin
                    front_buf_d = ~front_buf_q;
                    swap_done   = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= S_IDLE;
            front_buf_q <= 1'b0;
            prdata_q    <= 32'h0;
            control_q   <= 32'h1;
            ppr_q       <= 10'd64;
            mem_wr_q    <= 1'b0;
            mem_data_q  <= '0;
            mem_waddr_q <= '0;
        end else begin
            state_q     <= state_d;
            front_buf_q <= front_buf_d;
            prdata_q    <= prdata_d;
            control_q   <= control_d;
            ppr_q       <= ppr_d;
            mem_wr_q    <= mem_wr_d;
            mem_data_q  <= mem_data_d;
            mem_waddr_q <= mem_waddr_d;
        end
    end

`ifdef HUB75_IRQ_EN
    logic irq_pend_q, irq_pend_d, irq_en_q, irq_en_d, irq_q;

    // A swap completing in the same cycle as a clear wins.
    always_comb begin
        irq_pend_d = irq_pend_q;
        irq_en_d   = irq_en_q;
        if (reg_wr && is_irq) begin
            if (pwdata_i[0]) irq_pend_d = 1'b0;
            irq_en_d = pwdata_i[1];
        end
        if (swap_done) irq_pend_d = 1'b1;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            irq_pend_q <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_pend_q <= irq_pend_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_pend_d & irq_en_d;
        end
    end

    assign irq_pend = irq_pend_q;
    assign irq_en   = irq_en_q;
    assign irq_o    = irq_q;
`else
    assign irq_pend = 1'b0;
    assign irq_en   = 1'b0;
    assign irq_o    = 1'b0;
`endif

    assign prdata_o         = prdata_q;
    assign control_o        = control_q;
    assign pixels_per_row_o = ppr_q;
    assign front_buf_o      = front_buf_q;
    assign mem_wr_o         = mem_wr_q;
    assign mem_data_o       = mem_data_q;
    assign mem_waddr_o      = mem_waddr_q;

endmodule

// File: tb/tb_hub75_apb_regs.sv
// Directed + randomized bench for hub75_apb_regs against a register-level reference model.
module tb_hub75_apb_regs;
    localparam int ADDR_W = 18;
    localparam int PIX_W  = 16;
    localparam int FB_AW  = ADDR_W - 3;

    logic              pclk = 1'b0, presetn = 1'b0;
    logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [31:0]       pwdata = '0;
    logic [31:0]       prdata;
    logic              pready, pslverr;
    logic              frame_end = 1'b0;
    logic [31:0]       control;
    logic [9:0]        ppr;
    logic              front_buf, irq, mem_wr;
    logic [PIX_W-1:0]  mem_data;
    logic [FB_AW:0]    mem_waddr;

    hub75_apb_regs #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
        .pclk(pclk), .presetn(presetn),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata),
        .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
        .frame_end_i(frame_end), .control_o(control),
        .pixels_per_row_o(ppr), .front_buf_o(front_buf), .irq_o(irq),
        .mem_wr_o(mem_wr), .mem_data_o(mem_data), .mem_waddr_o(mem_waddr)
    );

    always #5 pclk = ~pclk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    logic        fb_m   = 1'b0;
    logic [31:0] ctrl_m = 32'h1;
    int          ppr_m  = 64;

    logic [PIX_W-1:0] mq_d[$];
    logic [FB_AW:0]   mq_a[$];
    always @(negedge pclk) if (mem_wr) begin
        mq_d.push_back(mem_data);
        mq_a.push_back(mem_waddr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] reg_a(input int off);
        return ADDR_W'((1 << (ADDR_W-1)) + off * 4);
    endfunction

    function automatic logic [ADDR_W-1:0] fb_a(input int word);
        return ADDR_W'(word * 4);
    endfunction

    function automatic logic [31:0] exp_pix(input logic [31:0] d);
        int r, g, b;
        r = (d >> 16) & 255; g = (d >> 8) & 255; b = d & 255;
        if (PIX_W == 16) return (r / 8) * 2048 + (g / 4) * 32 + (b / 8);
        return d & 32'hFFFFFF;
    endfunction

    task automatic apb_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                             output logic err, output int stalls);
        @(posedge pclk); #1;
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1;
        stalls = 0;
        @(negedge pclk);
        while (!pready && stalls < 200) begin
            stalls++;
            @(negedge pclk);
        end
        if (!pready) chk("write_timeout", {31'b0, pready}, 32'h1);
        err = pslverr;
        @(posedge pclk); #1;
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic err);
        int n;
        @(posedge pclk); #1;
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(posedge pclk); #1;
        penable = 1;
        n = 0;
        @(negedge pclk);
        while (!pready && n < 200) begin
            n++;
            @(negedge pclk);
        end
        if (!pready) chk("read_timeout", {31'b0, pready}, 32'h1);
        d = prdata;
        err = pslverr;
        @(posedge pclk); #1;
        psel = 0; penable = 0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input string tag,
                      input logic exp_err);
        logic e; int s;
        apb_write(a, d, e, s);
        chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input string tag,
                      input logic [31:0] exp, input logic exp_err);
        logic [31:0] d; logic e;
        apb_read(a, d, e);
        chk(tag, d, exp);
        chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    endtask

    task automatic chk_pix(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        logic [FB_AW:0] ea;
        ea = {~fb_m, a[FB_AW+1:2]};
        @(negedge pclk); @(negedge pclk);
        chk({tag, "_pulses"}, mq_d.size(), 1);
        if (mq_d.size() >= 1) begin
            chk({tag, "_data"}, 32'(mq_d[0]), exp_pix(d));
            chk({tag, "_waddr"}, 32'(mq_a[0]), 32'(ea));
        end
        mq_d.delete(); mq_a.delete();
    endtask

    task automatic pulse_fe();
        @(posedge pclk); #1 frame_end = 1;
        @(posedge pclk); #1 frame_end = 0;
    endtask

    function automatic logic [31:0] status_m(input logic pend);
        return 32'hB0750000 | (32'(pend) << 1) | 32'(fb_m);
    endfunction

    initial begin
        logic e; int s; int cnt;
        logic [ADDR_W-1:0] a; logic [31:0] d;

        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("rst_prdata", prdata, 0);
        chk("rst_control", control, 1);
        chk("rst_ppr", 32'(ppr), 64);
        chk("rst_front", {31'b0, front_buf}, 0);
        chk("rst_irq", {31'b0, irq}, 0);
        chk("rst_memwr", {31'b0, mem_wr}, 0);
        chk("rst_memdata", 32'(mem_data), 0);
        chk("rst_memwaddr", 32'(mem_waddr), 0);
        @(posedge pclk); #1 presetn = 1;

        rd(reg_a(0), "status0", 32'hB0750000, 0);
        rd(reg_a(1), "control0", 32'h1, 0);
        rd(reg_a(2), "pprow0", 64, 0);

        mq_d.delete(); mq_a.delete();
        apb_write(fb_a(5), 32'h00FF8040, e, s);
        chk_pix("pix_w5", fb_a(5), 32'h00FF8040);
        chk("pix_w5_lit", exp_pix(32'h00FF8040), 32'hFC08);

        // Reset in PENDING abandons the swap.
        wr(reg_a(3), 1, "swap_a", 0);
        rd(reg_a(0), "status_pend", status_m(1), 0);
        @(posedge pclk); #1 presetn = 0;
        @(negedge pclk);
        chk("rst_pend_front", {31'b0, front_buf}, 0);
        @(posedge pclk); #1 presetn = 1;
        pulse_fe();
        @(negedge pclk);
        chk("rst_pend_front2", {31'b0, front_buf}, 0);
        rd(reg_a(0), "status_after_rst", status_m(0), 0);

        // Pixel write stalls until the swap completes.
        wr(reg_a(3), 1, "swap_b", 0);
        mq_d.delete(); mq_a.delete();
        fork
            apb_write(fb_a(9), 32'h00123456, e, s);
            begin
                repeat (21) @(posedge pclk);
                #1 frame_end = 1;
                @(posedge pclk); #1 frame_end = 0;
            end
        join
        fb_m = ~fb_m;
        chk("stall_cycles", s, 20);
        chk("stall_front", {31'b0, front_buf}, {31'b0, fb_m});
        chk_pix("pix_after_swap", fb_a(9), 32'h00123456);

        // frame_end coincident with the SWAP write is ignored.
        fork
            wr(reg_a(3), 1, "swap_c", 0);
            begin
                repeat (2) @(posedge pclk);
                #1 frame_end = 1;
                @(posedge pclk); #1 frame_end = 0;
            end
        join
        rd(reg_a(0), "status_coinc", status_m(1), 0);
        wr(reg_a(3), 1, "swap_in_pend", 0);
        pulse_fe();
        fb_m = ~fb_m;
        @(negedge pclk);
        chk("coinc_front", {31'b0, front_buf}, {31'b0, fb_m});
        rd(reg_a(0), "status_idle", status_m(0), 0);

        wr(reg_a(2), 200, "ppr200", 0);
        chk("ppr200_val", 32'(ppr), 192);
        wr(reg_a(2), 100, "ppr100", 0);
        chk("ppr100_val", 32'(ppr), 64);
        wr(reg_a(2), 32, "ppr32", 1);
        chk("ppr32_val", 32'(ppr), 64);

        rd(reg_a(7), "unmapped7", 0, 1);
        wr(reg_a(7), 32'hDEAD, "unmapped7_wr", 1);
        chk("ctrl_after_unmapped", control, 1);
        rd(fb_a(3), "fb_read", 0, 0);

`ifdef HUB75_IRQ_EN
        wr(reg_a(4), 2, "irq_en", 0);
        rd(reg_a(4), "irq_reg_en", 2, 0);
        wr(reg_a(3), 1, "swap_irq", 0);
        pulse_fe();
        fb_m = ~fb_m;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("irq_set", {31'b0, irq}, 1);
        rd(reg_a(0), "status_irq", status_m(0) | 32'h4, 0);
        wr(reg_a(4), 3, "irq_clr", 0);
        @(posedge pclk); #1;
        chk("irq_cleared", {31'b0, irq}, 0);
        rd(reg_a(4), "irq_reg_after", 2, 0);
`else
        rd(reg_a(4), "irq_unmapped", 0, 1);
        wr(reg_a(3), 1, "swap_noirq", 0);
        pulse_fe();
        fb_m = ~fb_m;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("irq_tied", {31'b0, irq}, 0);
        rd(reg_a(0), "status_noirq", status_m(0), 0);
`endif

        // Timing disabled: swap completes without frame_end.
        wr(reg_a(1), 0, "ctrl0", 0);
        chk("ctrl0_val", control, 0);
        wr(reg_a(3), 1, "swap_ctl0", 0);
        cnt = 0;
        while (front_buf == fb_m && cnt < 5) begin
            @(posedge pclk); #1;
            cnt++;
        end
        fb_m = ~fb_m;
        chk("ctl0_latency_ok", {31'b0, cnt <= 2}, 1);
        chk("ctl0_front", {31'b0, front_buf}, {31'b0, fb_m});
        wr(reg_a(1), 1, "ctrl1", 0);
        ctrl_m = 1;

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: begin
                    a = fb_a($urandom_range(0, (1 << FB_AW) - 1));
                    d = $urandom;
                    mq_d.delete(); mq_a.delete();
                    apb_write(a, d, e, s);
                    chk($sformatf("r%0d_pix_err", i), {31'b0, e}, 0);
                    chk_pix($sformatf("r%0d_pix", i), a, d);
                end
                1: begin
                    d = $urandom | 32'h1;
                    ctrl_m = d;
                    wr(reg_a(1), d, $sformatf("r%0d_ctrl", i), 0);
                    chk($sformatf("r%0d_ctrl_out", i), control, ctrl_m);
                end
                2: begin
                    d = $urandom;
                    cnt = (d % 1024) / 64 * 64;
                    wr(reg_a(2), d, $sformatf("r%0d_ppr", i), cnt == 0);
                    if (cnt != 0) ppr_m = cnt;
                    chk($sformatf("r%0d_ppr_out", i), 32'(ppr), ppr_m);
                end
                3: begin
                    rd(reg_a(0), $sformatf("r%0d_status", i), status_m(0), 0);
                    rd(reg_a(1), $sformatf("r%0d_rdctrl", i), ctrl_m, 0);
                    rd(reg_a(2), $sformatf("r%0d_rdppr", i), ppr_m, 0);
                end
                default: begin
                    rd(reg_a($urandom_range(5, (1 << FB_AW) - 1)), $sformatf("r%0d_unmapped", i), 0, 1);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
